logic_op_scheduler: RTL

Sequencer and two-requester arbiter for the shared 4-function logic unit (AND/OR/XOR/NOT with Z/N/P flags). It accepts operation requests from two independent clients over valid/ready handshakes and grants them round-robin. It registers the operands and opcode onto the logic unit's inputs, captures its combinational result and flags, and returns a tagged response over a valid/ready response channel. One operation is in flight at a time.

---
 rtl/logic_op_scheduler_pkg.sv | 36 +++
 rtl/logic_op_scheduler_arb.sv | 28 ++
 rtl/logic_op_scheduler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/logic_op_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : logic_op_scheduler_pkg
// Purpose  : Shared definitions for the logic-unit scheduler, the logic unit
//            itself and future ALU controllers: FSM state encoding and the
//            logic-unit opcode map.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package logic_op_scheduler_pkg;

  // Scheduler FSM state encoding
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_ISSUE   = ISSUE,
    ST_CAPTURE = CAPTURE,
    ST_RESP    = RESP
  } sched_state_t;

  // Logic-unit opcodes; F[2]=1 is reserved and treated as unsupported
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;

  function automatic logic op_unsupported(input logic [2:0] f);
    return f[2];
  endfunction

endpackage : logic_op_scheduler_pkg
`default_nettype wire

// File: rtl/logic_op_scheduler_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Combinational two-way round-robin arbiter. On contention the
//            requester that was not granted last wins.
// Ports    : req_valid_i  [1:0] per-requester request
//            last_grant_i       index of the most recently granted requester
//            grant_o      [1:0] one-hot grant (all zero when no request)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic [1:0] req_valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (req_valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/logic_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : logic_op_scheduler
// Purpose  : Two-requester sequencer for the shared AND/OR/XOR/NOT logic
//            unit. Accepts one operation at a time round-robin, drives the
//            unit with registered operands, captures its result and flags,
//            and returns a tagged response over valid/ready.
// Ports    : clk, rst (async, active-high)
//            req_valid/req_ready [1:0], req_a/req_b [2*Width], req_f [6]
//            rsp_valid/rsp_ready, rsp_id, rsp_out [Width],
//            rsp_z/rsp_n/rsp_p/rsp_err
//            alu_a/alu_b [Width], alu_f [3] (to logic unit)
//            alu_out [Width], alu_z/alu_n/alu_p (from logic unit)
//            busy (high outside IDLE)
// Revision : 1.0 - initial release
// ============================================================================
module logic_op_scheduler
  import logic_op_scheduler_pkg::*;
#(
  parameter int Width = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*Width-1:0] req_a,
  input  logic [2*Width-1:0] req_b,
  input  logic [5:0]         req_f,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [Width-1:0]   rsp_out,
  output logic               rsp_z,
  output logic               rsp_n,
  output logic               rsp_p,
  output logic               rsp_err,
  output logic [Width-1:0]   alu_a,
  output logic [Width-1:0]   alu_b,
  output logic [2:0]         alu_f,
  input  logic [Width-1:0]   alu_out,
  input  logic               alu_z,
  input  logic               alu_n,
  input  logic               alu_p,
  output logic               busy
);

  sched_state_t state_q, state_d;
  logic         last_grant_q;
  logic [1:0]   w_grant;
  logic         w_accept;
  logic         w_sel;

  rr_arbiter2 u_arb (
    .req_valid_i  (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (w_grant)
  );

  // Grant is only ever issued to a valid requester, so any ready bit is a
  // handshake.
  assign w_accept = |req_ready;
  assign w_sel    = w_grant[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy      = 1'b0;
        req_ready = w_grant;
        if (|w_grant) state_d = ST_ISSUE;
      end
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // last_grant resets to 1 so requester 0 wins the first contention. It also
  // serves as the id of the in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_f        <= 3'b000;
      rsp_id       <= 1'b0;
      rsp_out      <= '0;
      rsp_z        <= 1'b0;
      rsp_n        <= 1'b0;
      rsp_p        <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        last_grant_q <= w_sel;
        alu_a        <= w_sel ? req_a[Width +: Width] : req_a[0 +: Width];
        alu_b        <= w_sel ? req_b[Width +: Width] : req_b[0 +: Width];
        alu_f        <= w_sel ? req_f[3 +: 3] : req_f[0 +: 3];
      end
      if (state_q == ST_CAPTURE) begin
        rsp_id  <= last_grant_q;
        rsp_out <= alu_out;
        rsp_z   <= alu_z;
        rsp_n   <= alu_n;
        rsp_p   <= alu_p;
        rsp_err <= op_unsupported(alu_f);
      end
    end
  end

endmodule : logic_op_scheduler
`default_nettype wire
